// File: rtl/ddr_read_capture_if.sv
// Pin-side and read-return signals of the DDR read capture block.
// The controller/bench drives through master; the capture block uses slave.
interface ddr_read_capture_if;
  logic        rd_cmd;
  logic        rd_bc4;
  logic [5:0]  rd_delay;
  logic [1:0]  preamble;
  logic        dqs_t;
  logic [7:0]  dq_rise;
  logic [7:0]  dq_fall;
  logic [63:0] rdata;
  logic        rdata_valid;
  logic        rdata_bc4;
  logic        preamble_err;
  logic        rd_overflow;
  logic        rd_collision;
  logic        busy;

  modport master (
    output rd_cmd, rd_bc4, rd_delay, preamble, dqs_t, dq_rise, dq_fall,
    input  rdata, rdata_valid, rdata_bc4, preamble_err, rd_overflow,
           rd_collision, busy
  );

  modport slave (
    input  rd_cmd, rd_bc4, rd_delay, preamble, dqs_t, dq_rise, dq_fall,
    output rdata, rdata_valid, rdata_bc4, preamble_err, rd_overflow,
           rd_collision, busy
  );
endinterface

// File: rtl/ddr_read_capture.sv
// Captures DQ beat pairs returned after each READ CAS, rebuilds the 64-bit burst,
// tracks outstanding reads against read latency and flags protocol errors.
module ddr_read_capture #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clock_t,
  input  logic               reset_n,
  ddr_read_capture_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  typedef enum logic {IDLE, CAPTURE} state_e;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] due_mem [DEPTH];
  logic             bc4_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      fill_q;

  state_e      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic        cur_bc4_q, cur_bc4_d;
  logic [63:0] asm_q, asm_d, merged;
  logic [63:0] rdata_q, rdata_d;
  logic        rdata_bc4_q, rdata_bc4_d;
  logic        valid_q, valid_d;
  logic        coll_q, coll_d;
  logic        pre_err_q, ovf_q;

  logic             empty, full, due_hit, push, pop;
  logic             last_pair, pre_window, in_data, head_bc4;
  logic [CNT_W-1:0] head_due, lead;
  logic [15:0]      pair;

  // ---------------------------------------------------------------------------
  // Outstanding-read queue, keyed by the cycle stamp at which beat 0 is due.
  // Every head entry is popped exactly at its due cycle: start, seamless or drop.
  // ---------------------------------------------------------------------------
  assign empty    = (fill_q == '0);
  assign full     = (fill_q == FULL_LVL);
  assign head_due = due_mem[rd_ptr_q];
  assign head_bc4 = bc4_mem[rd_ptr_q];
  assign due_hit  = !empty && (cnt_q == head_due);
  assign pop      = due_hit;
  assign push     = bus.rd_cmd && (!full || pop);

  // Modular distance to the head's first beat; only tiny values are meaningful.
  assign lead       = head_due - cnt_q;
  assign pre_window = !empty && (lead != '0) && (lead <= CNT_W'(bus.preamble));
  assign in_data    = (state_q == CAPTURE) || due_hit;

  assign last_pair = cur_bc4_q ? (beat_q == 2'd1) : (beat_q == 2'd3);
  assign pair      = {bus.dq_fall, bus.dq_rise};

  // NOTE: queue storage carries no reset; the pointers and fill level alone
  // define which entries are live, so stale contents are never observed.
  always_ff @(posedge clock_t) begin
    if (push) begin
      due_mem[wr_ptr_q] <= cnt_q + CNT_W'(bus.rd_delay);
      bc4_mem[wr_ptr_q] <= bus.rd_bc4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
      pre_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
      ovf_q     <= bus.rd_cmd && full && !pop;
      pre_err_q <= pre_window && !in_data && bus.dqs_t;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM: state register / next-state / datapath-and-output logic.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (due_hit) state_d = CAPTURE;
      CAPTURE: if (last_pair && !due_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Current burst with this cycle's pair inserted; chopped bursts keep the top half zero.
  always_comb begin
    merged = asm_q;
    merged[{beat_q, 4'b0000} +: 16] = pair;
    if (cur_bc4_q) merged[63:32] = '0;
  end

  always_comb begin
    asm_d       = asm_q;
    beat_d      = beat_q;
    cur_bc4_d   = cur_bc4_q;
    rdata_d     = rdata_q;
    rdata_bc4_d = rdata_bc4_q;
    valid_d     = 1'b0;
    coll_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (due_hit) begin
          asm_d     = {48'h0, pair};
          beat_d    = 2'd1;
          cur_bc4_d = head_bc4;
        end
      end
      CAPTURE: begin
        if (last_pair) begin
          rdata_d     = merged;
          rdata_bc4_d = cur_bc4_q;
          valid_d     = 1'b1;
          if (due_hit) begin
            asm_d     = {48'h0, pair};
            beat_d    = 2'd1;
            cur_bc4_d = head_bc4;
          end
        end else begin
          asm_d  = merged;
          beat_d = beat_q + 2'd1;
          coll_d = due_hit;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      beat_q      <= 2'd0;
      cur_bc4_q   <= 1'b0;
      asm_q       <= '0;
      rdata_q     <= '0;
      rdata_bc4_q <= 1'b0;
      valid_q     <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      cur_bc4_q   <= cur_bc4_d;
      asm_q       <= asm_d;
      rdata_q     <= rdata_d;
      rdata_bc4_q <= rdata_bc4_d;
      valid_q     <= valid_d;
      coll_q      <= coll_d;
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.rdata_valid  = valid_q;
  assign bus.rdata_bc4    = rdata_bc4_q;
  assign bus.preamble_err = pre_err_q;
  assign bus.rd_overflow  = ovf_q;
  assign bus.rd_collision = coll_q;
  assign bus.busy         = !empty || (state_q == CAPTURE);

endmodule

// File: tb/tb_ddr_read_capture.sv
// Scenario bench for ddr_read_capture: expected bursts go into a scoreboard queue
// and are popped by a monitor on each rdata_valid; pulse counts are checked per scenario.
module tb_ddr_read_capture;

  logic clock_t;
  logic reset_n;

  ddr_read_capture_if bus ();

  ddr_read_capture #(.DEPTH(4), .CNT_W(8)) dut (
    .clock_t (clock_t),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        bc4;
  } exp_t;

  exp_t exp_q[$];
  int   checks, failures;
  int   edge_n;
  int   n_valid, n_coll, n_ovf, n_pre;

  bit          cmd_at  [int];
  bit          bc4_at  [int];
  bit          dqs_at  [int];
  logic [15:0] pair_at [int];

  initial begin
    clock_t = 1'b0;
    forever #5 clock_t = ~clock_t;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  // {fall, rise} driven at a given edge; default pattern differs per edge.
  function automatic logic [15:0] pair_for(int e);
    logic [7:0] b;
    if (pair_at.exists(e)) return pair_at[e];
    b = 8'(e);
    return {~b, b};
  endfunction

  function automatic logic [63:0] burst_for(int start, bit bc4);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < (bc4 ? 2 : 4); k++) w[16*k +: 16] = pair_for(start + k);
    return w;
  endfunction

  // Monitor: sampled on the falling edge, away from the capture edge.
  always @(negedge clock_t) begin
    if (reset_n === 1'b1) begin
      if (bus.rd_collision === 1'b1) n_coll++;
      if (bus.rd_overflow === 1'b1)  n_ovf++;
      if (bus.preamble_err === 1'b1) n_pre++;
      if (bus.rdata_valid === 1'b1) begin
        n_valid++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected rdata=%h bc4=%b with no burst expected", bus.rdata, bus.rdata_bc4);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus.rdata !== e.data) begin
            failures++;
            $display("FAIL sb_rdata got=%h exp=%h", bus.rdata, e.data);
          end
          checks++;
          if (bus.rdata_bc4 !== e.bc4) begin
            failures++;
            $display("FAIL sb_rdata_bc4 got=%b exp=%b", bus.rdata_bc4, e.bc4);
          end
        end
      end
    end
  end

  task automatic tick();
    bus.rd_cmd = cmd_at.exists(edge_n);
    bus.rd_bc4 = bc4_at.exists(edge_n);
    bus.dqs_t  = dqs_at.exists(edge_n);
    {bus.dq_fall, bus.dq_rise} = pair_for(edge_n);
    @(posedge clock_t);
    #1;
    edge_n++;
  endtask

  // Runs through edge e inclusive; returns 1 time unit after that edge.
  task automatic run_to(int e);
    while (edge_n <= e) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.rd_cmd = 1'b0;
    bus.rd_bc4 = 1'b0;
    bus.dqs_t  = 1'b0;
    bus.dq_rise = '0;
    bus.dq_fall = '0;
    cmd_at.delete();
    bc4_at.delete();
    dqs_at.delete();
    pair_at.delete();
    exp_q.delete();
    repeat (3) @(posedge clock_t);
    #1;
    n_valid = 0; n_coll = 0; n_ovf = 0; n_pre = 0;
    edge_n  = 0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.rd_delay = 6'd5;
    bus.preamble = 2'd2;
    bus.rd_cmd = 1'b0; bus.rd_bc4 = 1'b0; bus.dqs_t = 1'b0;
    bus.dq_rise = '0;  bus.dq_fall = '0;
    repeat (2) @(posedge clock_t);
    #1;
    checks++; if (bus.rdata !== 64'h0)       begin failures++; $display("FAIL rst_rdata got=%h exp=0", bus.rdata); end
    checks++; if (bus.rdata_valid !== 1'b0)  begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.rdata_valid); end
    checks++; if (bus.rdata_bc4 !== 1'b0)    begin failures++; $display("FAIL rst_bc4 got=%b exp=0", bus.rdata_bc4); end
    checks++; if (bus.preamble_err !== 1'b0) begin failures++; $display("FAIL rst_pre got=%b exp=0", bus.preamble_err); end
    checks++; if (bus.rd_overflow !== 1'b0)  begin failures++; $display("FAIL rst_ovf got=%b exp=0", bus.rd_overflow); end
    checks++; if (bus.rd_collision !== 1'b0) begin failures++; $display("FAIL rst_coll got=%b exp=0", bus.rd_collision); end
    checks++; if (bus.busy !== 1'b0)         begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    do_reset();
    run_to(8);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
    checks++; if (n_valid !== 0)     begin failures++; $display("FAIL idle_valid got=%0d exp=0", n_valid); end
  endtask

  task automatic test_single_bl8();
    bus.rd_delay = 6'd5; bus.preamble = 2'd2;
    do_reset();
    cmd_at[10] = 1'b1;
    pair_at[15] = 16'h7766; pair_at[16] = 16'hBBAA;
    pair_at[17] = 16'hDDCC; pair_at[18] = 16'hFFEE;
    exp_q.push_back('{data: 64'hFFEEDDCCBBAA7766, bc4: 1'b0});
    run_to(10);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL bl8_busy got=%b exp=1", bus.busy); end
    run_to(17);
    checks++; if (bus.rdata_valid !== 1'b0) begin failures++; $display("FAIL bl8_early got=%b exp=0", bus.rdata_valid); end
    run_to(18);
    checks++; if (bus.rdata_valid !== 1'b1) begin failures++; $display("FAIL bl8_latency got=%b exp=1", bus.rdata_valid); end
    run_to(19);
    checks++; if (bus.rdata_valid !== 1'b0) begin failures++; $display("FAIL bl8_pulse got=%b exp=0", bus.rdata_valid); end
    run_to(25);
    checks++; if (n_valid !== 1)      begin failures++; $display("FAIL bl8_count got=%0d exp=1", n_valid); end
    checks++; if (n_pre + n_coll + n_ovf !== 0) begin failures++; $display("FAIL bl8_errs got=%0d exp=0", n_pre + n_coll + n_ovf); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL bl8_missing got=%0d exp=0", exp_q.size()); end
    checks++; if (bus.busy !== 1'b0)  begin failures++; $display("FAIL bl8_done_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_bc4();
    bus.rd_delay = 6'd5; bus.preamble = 2'd2;
    do_reset();
    cmd_at[10] = 1'b1; bc4_at[10] = 1'b1;
    pair_at[15] = 16'h7766; pair_at[16] = 16'hBBAA;
    exp_q.push_back('{data: 64'h00000000BBAA7766, bc4: 1'b1});
    run_to(16);
    checks++; if (bus.rdata_valid !== 1'b1) begin failures++; $display("FAIL bc4_latency got=%b exp=1", bus.rdata_valid); end
    checks++; if (bus.rdata_bc4 !== 1'b1)   begin failures++; $display("FAIL bc4_flag got=%b exp=1", bus.rdata_bc4); end
    run_to(24);
    checks++; if (n_valid !== 1)      begin failures++; $display("FAIL bc4_count got=%0d exp=1", n_valid); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL bc4_missing got=%0d exp=0", exp_q.size()); end
    checks++; if (bus.busy !== 1'b0)  begin failures++; $display("FAIL bc4_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    bus.rd_delay = 6'd5; bus.preamble = 2'd2;
    do_reset();
    cmd_at[10] = 1'b1; cmd_at[14] = 1'b1;
    // Strobe active through both bursts, including the second burst's preamble slots.
    for (int e = 15; e <= 22; e++) dqs_at[e] = 1'b1;
    exp_q.push_back('{data: burst_for(15, 1'b0), bc4: 1'b0});
    exp_q.push_back('{data: burst_for(19, 1'b0), bc4: 1'b0});
    run_to(18);
    checks++; if (bus.rdata_valid !== 1'b1) begin failures++; $display("FAIL b2b_first got=%b exp=1", bus.rdata_valid); end
    run_to(22);
    checks++; if (bus.rdata_valid !== 1'b1) begin failures++; $display("FAIL b2b_second got=%b exp=1", bus.rdata_valid); end
    checks++; if (n_valid !== 1)            begin failures++; $display("FAIL b2b_gap got=%0d exp=1", n_valid); end
    run_to(30);
    checks++; if (n_valid !== 2)      begin failures++; $display("FAIL b2b_count got=%0d exp=2", n_valid); end
    checks++; if (n_pre !== 0)        begin failures++; $display("FAIL b2b_preamble got=%0d exp=0", n_pre); end
    checks++; if (n_coll !== 0)       begin failures++; $display("FAIL b2b_coll got=%0d exp=0", n_coll); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL b2b_missing got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_collision();
    bus.rd_delay = 6'd5; bus.preamble = 2'd2;
    do_reset();
    cmd_at[10] = 1'b1; cmd_at[12] = 1'b1;
    exp_q.push_back('{data: burst_for(15, 1'b0), bc4: 1'b0});
    run_to(17);
    checks++; if (bus.rd_collision !== 1'b1) begin failures++; $display("FAIL coll_pulse got=%b exp=1", bus.rd_collision); end
    run_to(26);
    checks++; if (n_coll !== 1)       begin failures++; $display("FAIL coll_count got=%0d exp=1", n_coll); end
    checks++; if (n_valid !== 1)      begin failures++; $display("FAIL coll_valid got=%0d exp=1", n_valid); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL coll_missing got=%0d exp=0", exp_q.size()); end
    checks++; if (bus.busy !== 1'b0)  begin failures++; $display("FAIL coll_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_overflow();
    bus.rd_delay = 6'd20; bus.preamble = 2'd2;
    do_reset();
    for (int e = 10; e <= 14; e++) cmd_at[e] = 1'b1;
    // Dues 30..33: entries at 31,32 collide, 33 lands on the final beat (seamless).
    exp_q.push_back('{data: burst_for(30, 1'b0), bc4: 1'b0});
    exp_q.push_back('{data: burst_for(33, 1'b0), bc4: 1'b0});
    run_to(13);
    checks++; if (bus.rd_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", bus.rd_overflow); end
    run_to(14);
    checks++; if (bus.rd_overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", bus.rd_overflow); end
    run_to(45);
    checks++; if (n_ovf !== 1)        begin failures++; $display("FAIL ovf_count got=%0d exp=1", n_ovf); end
    checks++; if (n_coll !== 2)       begin failures++; $display("FAIL ovf_coll got=%0d exp=2", n_coll); end
    checks++; if (n_valid !== 2)      begin failures++; $display("FAIL ovf_valid got=%0d exp=2", n_valid); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL ovf_missing got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_preamble();
    bus.rd_delay = 6'd5; bus.preamble = 2'd2;
    do_reset();
    cmd_at[10] = 1'b1; dqs_at[14] = 1'b1;
    exp_q.push_back('{data: burst_for(15, 1'b0), bc4: 1'b0});
    run_to(14);
    checks++; if (bus.preamble_err !== 1'b1) begin failures++; $display("FAIL pre_pulse got=%b exp=1", bus.preamble_err); end
    run_to(25);
    checks++; if (n_pre !== 1)        begin failures++; $display("FAIL pre_count got=%0d exp=1", n_pre); end
    checks++; if (n_valid !== 1)      begin failures++; $display("FAIL pre_valid got=%0d exp=1", n_valid); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL pre_missing got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    bus.rd_delay = 6'd5; bus.preamble = 2'd2;
    do_reset();
    // Command at cnt=253: due wraps to cnt=2 (edge 258); preamble slot cnt=1 is edge 257.
    cmd_at[253] = 1'b1; dqs_at[257] = 1'b1;
    exp_q.push_back('{data: burst_for(258, 1'b0), bc4: 1'b0});
    run_to(260);
    checks++; if (bus.rdata_valid !== 1'b0) begin failures++; $display("FAIL wrap_early got=%b exp=0", bus.rdata_valid); end
    run_to(261);
    checks++; if (bus.rdata_valid !== 1'b1) begin failures++; $display("FAIL wrap_latency got=%b exp=1", bus.rdata_valid); end
    run_to(268);
    checks++; if (n_pre !== 1)        begin failures++; $display("FAIL wrap_pre got=%0d exp=1", n_pre); end
    checks++; if (n_valid !== 1)      begin failures++; $display("FAIL wrap_valid got=%0d exp=1", n_valid); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL wrap_missing got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    bus.rd_delay = 6'd5; bus.preamble = 2'd2;
    do_reset();
    cmd_at[10] = 1'b1; cmd_at[13] = 1'b1;
    run_to(16);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0)        begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.rdata_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.rdata_valid); end
    checks++; if (n_valid !== 0)            begin failures++; $display("FAIL midrst_partial got=%0d exp=0", n_valid); end
    do_reset();
    run_to(8);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_flushed got=%b exp=0", bus.busy); end
    cmd_at[10] = 1'b1;
    exp_q.push_back('{data: burst_for(15, 1'b0), bc4: 1'b0});
    run_to(25);
    checks++; if (n_valid !== 1)      begin failures++; $display("FAIL midrst_after got=%0d exp=1", n_valid); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL midrst_missing got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    checks = 0; failures = 0; edge_n = 0;
    n_valid = 0; n_coll = 0; n_ovf = 0; n_pre = 0;
    reset_n = 1'b0;
    test_reset();
    test_single_bl8();
    test_bc4();
    test_back_to_back();
    test_collision();
    test_overflow();
    test_preamble();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
